// File: rtl/param_stack_pkg.sv
// Shared types and constants for the parametrised LIFO stack.
package param_stack_pkg;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE = 2'd0;
    localparam err_code_t ERR_OVF  = 2'd1;
    localparam err_code_t ERR_UNF  = 2'd2;

endpackage

// File: rtl/param_stack_if.sv
// Control/status bundle for param_stack.
// The high_water signal exists only when PARAM_STACK_HIGH_WATER_EN is defined.
interface param_stack_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    import param_stack_pkg::*;

    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  clear_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic [CNT_WIDTH-1:0]  count;
    logic                  empty;
    logic                  full;
    logic                  error;
    err_code_t             err_code;
`ifdef PARAM_STACK_HIGH_WATER_EN
    logic [CNT_WIDTH-1:0]  high_water;

    modport master (
        output push, pop, data_in, clear_err,
        input  data_out, count, empty, full, error, err_code, high_water
    );
    modport slave (
        input  push, pop, data_in, clear_err,
        output data_out, count, empty, full, error, err_code, high_water
    );
`else
    modport master (
        output push, pop, data_in, clear_err,
        input  data_out, count, empty, full, error, err_code
    );
    modport slave (
        input  push, pop, data_in, clear_err,
        output data_out, count, empty, full, error, err_code
    );
`endif

endinterface

// File: rtl/param_stack_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, combinational read, no reset.
module param_stack_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is asynchronous so the next top is available in the pop cycle.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with count, flags, replace-top and a sticky typed error.
// Optional PARAM_STACK_HIGH_WATER_EN adds a high_water occupancy tracker.
module param_stack
    import param_stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    param_stack_if.slave  bus
);

    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] top_q, top_d;
    logic                  error_q, error_d;
    err_code_t             code_q, code_d;
    err_code_t             event_code;
    logic                  is_empty, is_full;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic [DATA_WIDTH-1:0] rdata;
`ifdef PARAM_STACK_HIGH_WATER_EN
    logic [CNT_WIDTH-1:0]  hw_q, hw_d;
`endif

    param_stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.data_in),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Decode the operation from pre-edge state and compute next state.
    always_comb begin
        is_empty   = (count_q == '0);
        is_full    = (count_q == CNT_FULL);
        count_d    = count_q;
        top_d      = top_q;
        we         = 1'b0;
        waddr      = ADDR_WIDTH'(count_q);
        // Entry that becomes top after a pop; only used when count_q >= 2.
        raddr      = ADDR_WIDTH'(count_q - CNT_TWO);
        event_code = ERR_NONE;

        if (bus.push && bus.pop && !is_empty) begin
            // Replace top in place; legal even when full.
            we    = 1'b1;
            waddr = ADDR_WIDTH'(count_q - CNT_ONE);
            top_d = bus.data_in;
        end else if (bus.push) begin
            // Push+pop on an empty stack falls through here as a plain push.
            if (is_full) begin
                event_code = ERR_OVF;
            end else begin
                we      = 1'b1;
                count_d = count_q + CNT_ONE;
                top_d   = bus.data_in;
            end
        end else if (bus.pop) begin
            if (is_empty) begin
                event_code = ERR_UNF;
            end else begin
                count_d = count_q - CNT_ONE;
                top_d   = (count_q == CNT_ONE) ? '0 : rdata;
            end
        end

        error_d = error_q;
        code_d  = code_q;
        if (bus.clear_err) begin
            error_d = 1'b0;
            code_d  = ERR_NONE;
        end else if (!error_q && (event_code != ERR_NONE)) begin
            error_d = 1'b1;
            code_d  = event_code;
        end

`ifdef PARAM_STACK_HIGH_WATER_EN
        if (bus.clear_err) begin
            hw_d = count_d;
        end else begin
            hw_d = (count_d > hw_q) ? count_d : hw_q;
        end
`endif
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            top_q   <= '0;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
`ifdef PARAM_STACK_HIGH_WATER_EN
            hw_q    <= '0;
`endif
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            error_q <= error_d;
            code_q  <= code_d;
`ifdef PARAM_STACK_HIGH_WATER_EN
            hw_q    <= hw_d;
`endif
        end
    end

    // Drive registered status onto the bus.
    always_comb begin
        bus.data_out   = top_q;
        bus.count      = count_q;
        bus.empty      = (count_q == '0);
        bus.full       = (count_q == CNT_FULL);
        bus.error      = error_q;
        bus.err_code   = code_q;
`ifdef PARAM_STACK_HIGH_WATER_EN
        bus.high_water = hw_q;
`endif
    end

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH=4, DATA_WIDTH=8).
// A queue-based model is compared on every falling edge; directed steps add literal checks.
module tb_param_stack;

    localparam int unsigned DW = 8;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    bit   cmp_en;

    param_stack_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    param_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stack as a queue, top is the back element.
    logic [DW-1:0] q[$];
    bit            m_err;
    int            m_code;
    int            m_hw;

    always @(posedge clk or negedge reset_n) begin
        int ev;
        if (!reset_n) begin
            q.delete();
            m_err  = 1'b0;
            m_code = 0;
            m_hw   = 0;
        end else begin
            ev = 0;
            if (bus.push && bus.pop && q.size() > 0) begin
                q[q.size()-1] = bus.data_in;
            end else if (bus.push) begin
                if (q.size() == DEPTH) ev = 1;
                else q.push_back(bus.data_in);
            end else if (bus.pop) begin
                if (q.size() == 0) ev = 2;
                else void'(q.pop_back());
            end
            if (bus.clear_err) begin
                m_err  = 1'b0;
                m_code = 0;
            end else if (!m_err && ev != 0) begin
                m_err  = 1'b1;
                m_code = ev;
            end
            if (bus.clear_err) m_hw = q.size();
            else if (q.size() > m_hw) m_hw = q.size();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_count", 32'(bus.count), 32'(q.size()));
            check("cmp_data_out", 32'(bus.data_out), (q.size() == 0) ? 32'd0 : 32'(q[q.size()-1]));
            check("cmp_empty", 32'(bus.empty), 32'(q.size() == 0));
            check("cmp_full", 32'(bus.full), 32'(q.size() == DEPTH));
            check("cmp_error", 32'(bus.error), 32'(m_err));
            check("cmp_err_code", 32'(bus.err_code), 32'(m_code));
`ifdef PARAM_STACK_HIGH_WATER_EN
            check("cmp_high_water", 32'(bus.high_water), 32'(m_hw));
`endif
        end
    end

    // One clock cycle of stimulus; inputs return to idle 1 time unit after the edge.
    task automatic step(input bit ps, input bit pp, input logic [DW-1:0] d, input bit clr);
        bus.push      = ps;
        bus.pop       = pp;
        bus.data_in   = d;
        bus.clear_err = clr;
        @(posedge clk);
        #1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.data_in   = '0;
        bus.clear_err = 1'b0;
    endtask

    task automatic expect_state(input string tag, input int cnt, input int dout,
                                input int err, input int code);
        check({tag, "_count"}, 32'(bus.count), 32'(cnt));
        check({tag, "_data_out"}, 32'(bus.data_out), 32'(dout));
        check({tag, "_error"}, 32'(bus.error), 32'(err));
        check({tag, "_err_code"}, 32'(bus.err_code), 32'(code));
    endtask

    initial begin
        logic [DW-1:0] pops [4];
        pops[0] = 8'h33; pops[1] = 8'h22; pops[2] = 8'h11; pops[3] = 8'h00;
        checks = 0;
        failures = 0;
        cmp_en = 1'b0;
        bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0; bus.clear_err = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        cmp_en = 1'b1;

        // 1. Idle after reset.
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        expect_state("idle", 0, 0, 0, 0);
        check("idle_empty", 32'(bus.empty), 32'd1);
        check("idle_full", 32'(bus.full), 32'd0);

        // 2. Fill, then overflow.
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 0, 8'h33, 0);
        step(1, 0, 8'h44, 0);
        expect_state("fill", 4, 8'h44, 0, 0);
        check("fill_full", 32'(bus.full), 32'd1);
        step(1, 0, 8'h55, 0);
        expect_state("ovf", 4, 8'h44, 1, 1);

        // 3. Drain, then underflow keeps the first error code.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0);
            check("drain_data_out", 32'(bus.data_out), 32'(pops[i]));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        step(0, 1, 8'h00, 0);
        expect_state("unf_sticky", 0, 0, 1, 1);

        // 4. Replace top at count=2.
        step(0, 0, 8'h00, 1);
        expect_state("clr", 0, 0, 0, 0);
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        expect_state("two", 2, 8'h22, 0, 0);
        step(1, 1, 8'h99, 0);
        expect_state("replace", 2, 8'h99, 0, 0);
        step(0, 1, 8'h00, 0);
        expect_state("after_replace", 1, 8'h11, 0, 0);

        // 5. Push+pop on empty acts as push; underflow; clear wins over a new error.
        step(0, 1, 8'h00, 0);
        expect_state("to_empty", 0, 0, 0, 0);
        step(1, 1, 8'h5A, 0);
        expect_state("pp_empty", 1, 8'h5A, 0, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        expect_state("unf", 0, 0, 1, 2);
        step(0, 1, 8'h00, 1);
        expect_state("clr_pri", 0, 0, 0, 0);

        // 6. Asynchronous reset mid-cycle aborts an in-flight push.
        step(1, 0, 8'hA1, 0);
        step(1, 0, 8'hA2, 0);
        step(1, 0, 8'hA3, 0);
        expect_state("three", 3, 8'hA3, 0, 0);
`ifdef PARAM_STACK_HIGH_WATER_EN
        check("hw_three", 32'(bus.high_water), 32'd3);
`endif
        bus.push = 1'b1;
        bus.data_in = 8'hA4;
        #3 reset_n = 1'b0;
        #1;
        expect_state("async_rst", 0, 0, 0, 0);
        check("async_rst_empty", 32'(bus.empty), 32'd1);
        bus.push = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        step(0, 0, 8'h00, 0);
        expect_state("post_rst", 0, 0, 0, 0);
`ifdef PARAM_STACK_HIGH_WATER_EN
        check("hw_post_rst", 32'(bus.high_water), 32'd0);
`endif
        step(1, 0, 8'h01, 0);
        step(1, 0, 8'h02, 0);
        step(1, 0, 8'h03, 0);
        expect_state("refill", 3, 8'h03, 0, 0);
`ifdef PARAM_STACK_HIGH_WATER_EN
        check("hw_refill", 32'(bus.high_water), 32'd3);
`endif
        step(0, 0, 8'h00, 0);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
